// File: rtl/source_play_ctrl_pkg.sv
// Shared types and widths for the source waveform playback controller.
package source_play_ctrl_pkg;

    localparam int unsigned SEP_W = 12;
    localparam int unsigned REP_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/source_play_ctrl_if.sv
// Control, host-write, RAM and PCM stream signals of the playback controller.
// master = controller side, slave = register block / RAM / TX path side.
interface source_play_ctrl_if #(
    parameter int unsigned aw = 10,
    parameter int unsigned dw = 16
);
    import source_play_ctrl_pkg::*;

    logic             start;
    logic             abort;
    logic [SEP_W-1:0] sep;
    logic [aw-1:0]    signal_len;
    logic [REP_W-1:0] reps;
    logic             busy;
    logic             done;
    logic             host_wr;
    logic [aw-1:0]    host_addr;
    logic [dw-1:0]    host_wdata;
    logic             host_ack;
    logic [aw-1:0]    mem_addr;
    logic             mem_rd;
    logic             mem_wr;
    logic [dw-1:0]    mem_wdata;
    logic [dw-1:0]    mem_rdata;
    logic             pcm_out_valid;
    logic             pcm_out_ready;
    logic [dw-1:0]    pcm_out;

    modport master (
        input  start, abort, sep, signal_len, reps,
        input  host_wr, host_addr, host_wdata, mem_rdata, pcm_out_ready,
        output busy, done, host_ack, mem_addr, mem_rd, mem_wr, mem_wdata,
        output pcm_out_valid, pcm_out
    );

    modport slave (
        output start, abort, sep, signal_len, reps,
        output host_wr, host_addr, host_wdata, mem_rdata, pcm_out_ready,
        input  busy, done, host_ack, mem_addr, mem_rd, mem_wr, mem_wdata,
        input  pcm_out_valid, pcm_out
    );

endinterface

// File: rtl/source_play_ctrl_pcm_skid_buf.sv
// Two-entry PCM skid buffer with registered head (stream output) and flush.
module pcm_skid_buf #(
    parameter int unsigned dw = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready_c,
    input  logic [dw-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [dw-1:0] out_data,
    output logic [1:0]    count
);

    logic [dw-1:0] tail_q;
    logic          pop;
    logic          push;

    // A full buffer still takes a write in the cycle its head is popped.
    always_comb begin
        pop        = out_valid & out_ready;
        in_ready_c = (count != 2'd2) | pop;
        push       = in_valid & in_ready_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= 2'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            tail_q    <= '0;
        end else if (flush) begin
            count     <= 2'd0;
            out_valid <= 1'b0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) out_data <= in_data;
                    else               tail_q   <= in_data;
                    count     <= count + 2'd1;
                    out_valid <= 1'b1;
                end
                2'b01: begin
                    out_data  <= tail_q;
                    count     <= count - 2'd1;
                    out_valid <= (count == 2'd2);
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        out_data <= in_data;
                    end else begin
                        out_data <= tail_q;
                        tail_q   <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/source_play_ctrl.sv
// Waveform RAM playback sequencer and host-write arbiter feeding a PCM stream.
// Build option SOURCE_PLAY_LOOP_EN: reps=0 repeats forever until abort.
module source_play_ctrl
    import source_play_ctrl_pkg::*;
#(
    parameter int unsigned aw = 10,
    parameter int unsigned dw = 16
) (
    input  logic               pcm_clk,
    input  logic               rst,
    source_play_ctrl_if.master bus
);

    state_t           state_q, state_n;
    logic [aw-1:0]    addr_q, addr_n, len_q, len_n, rd_addr;
    logic [SEP_W-1:0] sep_q, sep_n, gap_q, gap_n;
    logic [REP_W-1:0] rep_q, rep_n;
    logic             inflight_q, inflight_n;
    logic             inf_q, inf_n;
    logic             busy_q, busy_n, done_q, done_n;
    logic             rd_en, host_ack, flush, zero_push, pop;
    logic             rd_elig, zeros_left, gap_end, accept, degen, loop_inf;
    logic             push_valid, buf_in_ready_c;
    logic [dw-1:0]    push_data;
    logic [1:0]       buf_count;
    logic [2:0]       occ;

    always_ff @(posedge pcm_clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            sep_q      <= '0;
            gap_q      <= '0;
            rep_q      <= '0;
            inflight_q <= 1'b0;
            inf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            addr_q     <= addr_n;
            len_q      <= len_n;
            sep_q      <= sep_n;
            gap_q      <= gap_n;
            rep_q      <= rep_n;
            inflight_q <= inflight_n;
            inf_q      <= inf_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        addr_n     = addr_q;
        len_n      = len_q;
        sep_n      = sep_q;
        gap_n      = gap_q;
        rep_n      = rep_q;
        inf_n      = inf_q;
        busy_n     = busy_q;
        done_n     = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = addr_q;
        zero_push  = 1'b0;
        flush      = 1'b0;
        gap_end    = 1'b0;
        pop        = bus.pcm_out_valid & bus.pcm_out_ready;
        // Buffer slots committed after this cycle's pop, including the read in flight.
        occ        = 3'(buf_count) + 3'(inflight_q) - 3'(pop);
        rd_elig    = occ < 3'd2;
        zeros_left = gap_q != sep_q;
        accept     = bus.start & ~busy_q;
`ifdef SOURCE_PLAY_LOOP_EN
        degen      = bus.signal_len == '0;
        loop_inf   = bus.reps == '0;
`else
        degen      = (bus.signal_len == '0) | (bus.reps == '0);
        loop_inf   = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                busy_n = 1'b0;
                if (accept) begin
                    len_n  = bus.signal_len;
                    sep_n  = bus.sep;
                    rep_n  = bus.reps;
                    inf_n  = loop_inf;
                    gap_n  = '0;
                    addr_n = '0;
                    busy_n = 1'b1;
                    if (degen) begin
                        done_n = 1'b1;
                    end else begin
                        // First read issues on the start cycle itself.
                        rd_en   = 1'b1;
                        rd_addr = '0;
                        if (bus.signal_len == aw'(1)) begin
                            state_n = ST_GAP;
                        end else begin
                            state_n = ST_PLAY;
                            addr_n  = aw'(1);
                        end
                    end
                end
            end
            ST_PLAY: begin
                if (rd_elig) begin
                    rd_en = 1'b1;
                    if (addr_q == len_q - aw'(1)) begin
                        addr_n  = '0;
                        state_n = ST_GAP;
                    end else begin
                        addr_n  = addr_q + aw'(1);
                    end
                end
            end
            ST_GAP: begin
                // Zeros wait for the last burst read to land so ordering holds.
                if (zeros_left & ~inflight_q & buf_in_ready_c) begin
                    zero_push = 1'b1;
                    gap_n     = gap_q + SEP_W'(1);
                end
                gap_end = ~zeros_left | (zero_push & ((gap_q + SEP_W'(1)) == sep_q));
                if (gap_end & (inf_q | (rep_q != REP_W'(1)))) begin
                    rep_n   = inf_q ? rep_q : rep_q - REP_W'(1);
                    gap_n   = '0;
                    addr_n  = '0;
                    state_n = ST_PLAY;
                end else if (~zeros_left & ~inflight_q &
                             ((buf_count == 2'd0) | ((buf_count == 2'd1) & pop))) begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    gap_n   = '0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (bus.abort) begin
            state_n   = ST_IDLE;
            busy_n    = 1'b0;
            done_n    = 1'b0;
            rd_en     = 1'b0;
            zero_push = 1'b0;
            flush     = 1'b1;
            addr_n    = '0;
            gap_n     = '0;
        end
        inflight_n = rd_en;
        host_ack   = bus.host_wr & ~rd_en & ((state_q != ST_PLAY) | ~rd_elig);
        push_valid = inflight_q | zero_push;
        push_data  = inflight_q ? bus.mem_rdata : '0;
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.host_ack  = host_ack;
    assign bus.mem_rd    = rd_en;
    assign bus.mem_wr    = host_ack;
    assign bus.mem_addr  = rd_en ? rd_addr : (host_ack ? bus.host_addr : '0);
    assign bus.mem_wdata = host_ack ? bus.host_wdata : '0;

    pcm_skid_buf #(.dw(dw)) u_skid (
        .clk        (pcm_clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (push_valid),
        .in_ready_c (buf_in_ready_c),
        .in_data    (push_data),
        .out_valid  (bus.pcm_out_valid),
        .out_ready  (bus.pcm_out_ready),
        .out_data   (bus.pcm_out),
        .count      (buf_count)
    );

endmodule

// File: tb/tb_source_play_ctrl.sv
// Directed bench for source_play_ctrl: RAM model, stream monitor, expected sequences.
module tb_source_play_ctrl;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 16;

    logic clk;
    logic rst;
    int   nchk = 0;
    int   nerr = 0;
    int   cyc  = 0;
    int   start_cyc = 0;
    int   ack_rel;
    int   dummy;
    int   base;
    int   d0;

    source_play_ctrl_if #(.aw(AW), .dw(DW)) bus ();

    source_play_ctrl #(.aw(AW), .dw(DW)) dut (
        .pcm_clk (clk),
        .rst     (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM with 1-cycle read latency
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.mem_wr) ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_rd) bus.mem_rdata <= ram[bus.mem_addr];
    end

    logic [DW-1:0] got [$];
    logic [DW-1:0] exp_q [$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            acc_cyc  = 0;
    bit            chk_stable = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_stable && prev_stall) begin
            check("stall_valid", 32'(bus.pcm_out_valid), 32'd1);
            check("stall_data", 32'(bus.pcm_out), 32'(prev_data));
        end
        prev_stall = bus.pcm_out_valid && !bus.pcm_out_ready;
        prev_data  = bus.pcm_out;
        if (bus.pcm_out_valid && bus.pcm_out_ready) begin
            got.push_back(bus.pcm_out);
            acc_cyc = cyc;
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_play(input int len, input int sep, input int reps);
        bus.signal_len = AW'(len);
        bus.sep        = 12'(sep);
        bus.reps       = 8'(reps);
        bus.start      = 1'b1;
        start_cyc      = cyc;
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit toggle);
        int n = 0;
        while (bus.busy && n < budget) begin
            if (toggle) bus.pcm_out_ready = ~bus.pcm_out_ready;
            tick();
            n++;
        end
        check("idle_timeout", 32'(bus.busy), 32'd0);
        bus.pcm_out_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic host_write(input int a, input int d, input int budget, output int rel);
        bit acked = 1'b0;
        int n = 0;
        bus.host_addr  = AW'(a);
        bus.host_wdata = DW'(d);
        bus.host_wr    = 1'b1;
        rel = -1;
        while (!acked && n < budget) begin
            @(negedge clk);
            acked = bus.host_ack;
            if (acked) rel = cyc - start_cyc;
            @(posedge clk);
            #1;
            n++;
        end
        bus.host_wr = 1'b0;
        check("host_ack_seen", 32'(acked), 32'd1);
    endtask

    task automatic compare_seq(input string tag, input int b);
        check({tag, "_count"}, 32'(got.size() - b), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_s%0d", tag, i),
                  (b + i < got.size()) ? 32'(got[b + i]) : 32'hdead_beef, 32'(exp_q[i]));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.sep = '0; bus.signal_len = '0;
        bus.reps = '0; bus.host_wr = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
        bus.pcm_out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.pcm_out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) host_write(i, i + 1, 5, dummy);

        // Basic playback, ready held high
        base = got.size(); d0 = done_cnt;
        start_play(4, 2, 2);
        check("t1_valid_c1", 32'(bus.pcm_out_valid), 32'd0);
        tick();
        check("t1_valid_c2", 32'(bus.pcm_out_valid), 32'd1);
        check("t1_first", 32'(bus.pcm_out), 32'd1);
        wait_idle(80, 1'b0);
        exp_q = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0};
        compare_seq("t1", base);
        check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("t1_done_lat", 32'(done_cyc - acc_cyc), 32'd1);

        // Ready toggling every cycle
        base = got.size(); d0 = done_cnt;
        chk_stable = 1'b1;
        start_play(4, 2, 2);
        wait_idle(150, 1'b1);
        chk_stable = 1'b0;
        compare_seq("t2", base);
        check("t2_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("t2_done_lat", 32'(done_cyc - acc_cyc), 32'd1);

        // Host write held during playback is granted in the gap
        base = got.size(); d0 = done_cnt;
        start_play(4, 2, 2);
        fork
            wait_idle(80, 1'b0);
            host_write(0, 9, 40, ack_rel);
        join
        check("t3_ack_cycle", 32'(ack_rel), 32'd4);
        check("t3_ram0", 32'(ram[0]), 32'd9);
        exp_q = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd9, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0};
        compare_seq("t3", base);
        host_write(0, 1, 5, dummy);

        // Abort while the third sample is presented
        base = got.size(); d0 = done_cnt;
        start_play(4, 2, 2);
        repeat (3) tick();
        check("t4_valid_s3", 32'(bus.pcm_out_valid), 32'd1);
        check("t4_data_s3", 32'(bus.pcm_out), 32'd3);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("t4_valid_after", 32'(bus.pcm_out_valid), 32'd0);
        check("t4_busy_after", 32'(bus.busy), 32'd0);
        repeat (5) tick();
        check("t4_no_done", 32'(done_cnt - d0), 32'd0);
        check("t4_accepted", 32'(got.size() - base), 32'd3);
        base = got.size(); d0 = done_cnt;
        start_play(4, 2, 2);
        wait_idle(80, 1'b0);
        exp_q = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0};
        compare_seq("t4r", base);
        check("t4r_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Degenerate start: zero length
        base = got.size();
        start_play(0, 3, 2);
        check("t5_done_c1", 32'(bus.done), 32'd1);
        check("t5_busy_c1", 32'(bus.busy), 32'd1);
        check("t5_valid_c1", 32'(bus.pcm_out_valid), 32'd0);
        tick();
        check("t5_done_c2", 32'(bus.done), 32'd0);
        check("t5_busy_c2", 32'(bus.busy), 32'd0);
        repeat (3) tick();
        check("t5_no_samples", 32'(got.size() - base), 32'd0);

`ifndef SOURCE_PLAY_LOOP_EN
        base = got.size();
        start_play(4, 1, 0);
        check("t5b_done_c1", 32'(bus.done), 32'd1);
        tick();
        check("t5b_busy_c2", 32'(bus.busy), 32'd0);
        repeat (3) tick();
        check("t5b_no_samples", 32'(got.size() - base), 32'd0);
`endif

        // sep=0 skips the zeros
        base = got.size(); d0 = done_cnt;
        start_play(3, 0, 3);
        wait_idle(80, 1'b0);
        exp_q = '{16'd1, 16'd2, 16'd3, 16'd1, 16'd2, 16'd3, 16'd1, 16'd2, 16'd3};
        compare_seq("t6", base);
        check("t6_done_cnt", 32'(done_cnt - d0), 32'd1);

`ifdef SOURCE_PLAY_LOOP_EN
        // Infinite repeat until abort
        begin
            logic [DW-1:0] pat [3];
            int n;
            pat = '{16'd1, 16'd2, 16'd0};
            base = got.size(); d0 = done_cnt;
            start_play(2, 1, 0);
            repeat (100) tick();
            check("t7_busy", 32'(bus.busy), 32'd1);
            bus.abort = 1'b1;
            tick();
            bus.abort = 1'b0;
            check("t7_valid_after", 32'(bus.pcm_out_valid), 32'd0);
            repeat (3) tick();
            n = got.size() - base;
            check("t7_enough", 32'(n >= 20), 32'd1);
            for (int i = 0; i < n; i++)
                check($sformatf("t7_s%0d", i), 32'(got[base + i]), 32'(pat[i % 3]));
            check("t7_no_done", 32'(done_cnt - d0), 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
